// File: rtl/jtkiwi_gfxslot_if.sv
// Bus bundle for the one-word graphics cache slot: client read port plus SDRAM read port.
// The slave modport is the slot's view; the master modport drives client and memory inputs.
interface jtkiwi_gfxslot_if;
    logic [19:2] addr;
    logic        cs;
    logic [31:0] data;
    logic        ok;
    logic [19:1] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic        mem_rdy;
    logic [15:0] mem_din;

    modport slave (
        input  addr, cs, mem_ack, mem_rdy, mem_din,
        output data, ok, mem_addr, mem_req
    );

    modport master (
        output addr, cs, mem_ack, mem_rdy, mem_din,
        input  data, ok, mem_addr, mem_req
    );
endinterface

// File: rtl/jtkiwi_gfxslot.sv
// One-entry 32-bit read cache between a graphics client and a 16-bit SDRAM port.
// A miss fetches two 16-bit beats; a started fetch always runs to completion.
module jtkiwi_gfxslot #(
    parameter bit SWAB = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    jtkiwi_gfxslot_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, REQ, BEAT0, BEAT1} state_t;

    state_t      st, st_nx;
    logic [19:2] tag, tag_nx;
    logic [19:2] pend, pend_nx;
    logic        valid, valid_nx;
    logic        req, req_nx;
    logic [31:0] cache, cache_nx;
    logic        hit;

    // Place a 16-bit beat into the upper or lower half of the cached word.
    function automatic logic [31:0] put_half(
        input logic [31:0] word,
        input logic [15:0] din,
        input logic        upper
    );
        logic [31:0] res;
        res = word;
        if (upper) res[31:16] = din;
        else       res[15:0]  = din;
        return res;
    endfunction

    assign hit          = bus.cs & valid & (bus.addr == tag);
    assign bus.ok       = hit;
    assign bus.data     = cache;
    assign bus.mem_addr = {pend, 1'b0};
    assign bus.mem_req  = req;

    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= IDLE;
            req   <= 1'b0;
            valid <= 1'b0;
            tag   <= '0;
            pend  <= '0;
            cache <= '0;
        end else begin
            st    <= st_nx;
            req   <= req_nx;
            valid <= valid_nx;
            tag   <= tag_nx;
            pend  <= pend_nx;
            cache <= cache_nx;
        end
    end

    always_comb begin
        st_nx    = st;
        req_nx   = req;
        valid_nx = valid;
        tag_nx   = tag;
        pend_nx  = pend;
        cache_nx = cache;
        unique case (st)
            IDLE: begin
                // valid drops here so ok cannot assert while the word is being refilled
                if (bus.cs && !hit) begin
                    pend_nx  = bus.addr;
                    req_nx   = 1'b1;
                    valid_nx = 1'b0;
                    st_nx    = REQ;
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    req_nx = 1'b0;
                    st_nx  = BEAT0;
                end
            end
            BEAT0: begin
                if (bus.mem_rdy) begin
                    cache_nx = put_half(cache, bus.mem_din, SWAB);
                    st_nx    = BEAT1;
                end
            end
            BEAT1: begin
                if (bus.mem_rdy) begin
                    cache_nx = put_half(cache, bus.mem_din, !SWAB);
                    tag_nx   = pend;
                    valid_nx = 1'b1;
                    st_nx    = IDLE;
                end
            end
            default: st_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_jtkiwi_gfxslot.sv
// Bench for jtkiwi_gfxslot: directed scenarios with literal expectations, then random
// client/memory traffic checked every cycle against a transaction-level cache model.
module tb_jtkiwi_gfxslot;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jtkiwi_gfxslot_if ifc0();
    jtkiwi_gfxslot_if ifc1();

    assign ifc1.addr    = ifc0.addr;
    assign ifc1.cs      = ifc0.cs;
    assign ifc1.mem_ack = ifc0.mem_ack;
    assign ifc1.mem_rdy = ifc0.mem_rdy;
    assign ifc1.mem_din = ifc0.mem_din;

    jtkiwi_gfxslot #(.SWAB(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(ifc0.slave));
    jtkiwi_gfxslot #(.SWAB(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(ifc1.slave));

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a fetch is outstanding, acknowledged or not, with 0 or 1 beats in.
    bit          m_busy  = 1'b0;
    bit          m_acked = 1'b0;
    bit          m_half  = 1'b0;
    bit          m_valid = 1'b0;
    logic [17:0] m_pend  = '0;
    logic [17:0] m_tag   = '0;
    logic [31:0] m_d0    = '0;
    logic [31:0] m_d1    = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_acked = 0; m_half = 0; m_valid = 0;
            m_pend = '0; m_tag = '0; m_d0 = '0; m_d1 = '0;
        end else if (!m_busy) begin
            if (ifc0.cs && !(m_valid && ifc0.addr == m_tag)) begin
                m_busy = 1; m_acked = 0; m_half = 0; m_valid = 0;
                m_pend = ifc0.addr;
            end
        end else if (!m_acked) begin
            m_acked = ifc0.mem_ack;
        end else if (ifc0.mem_rdy) begin
            if (!m_half) begin
                m_d0[15:0]  = ifc0.mem_din;
                m_d1[31:16] = ifc0.mem_din;
                m_half = 1;
            end else begin
                m_d0[31:16] = ifc0.mem_din;
                m_d1[15:0]  = ifc0.mem_din;
                m_tag   = m_pend;
                m_valid = 1;
                m_busy  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_ok;
            exp_ok = ifc0.cs && m_valid && (ifc0.addr == m_tag);
            check("ok0",       ifc0.ok,       exp_ok);
            check("ok1",       ifc1.ok,       exp_ok);
            check("mem_req0",  ifc0.mem_req,  m_busy && !m_acked);
            check("mem_req1",  ifc1.mem_req,  m_busy && !m_acked);
            check("mem_addr0", ifc0.mem_addr, {m_pend, 1'b0});
            check("mem_addr1", ifc1.mem_addr, {m_pend, 1'b0});
            check("data0",     ifc0.data,     m_d0);
            check("data1",     ifc1.data,     m_d1);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Call while the slot is waiting for ack: ack, then two beats.
    task automatic fetch_fill(input logic [15:0] b0, input logic [15:0] b1);
        ifc0.mem_ack = 1; tick; ifc0.mem_ack = 0;
        ifc0.mem_rdy = 1; ifc0.mem_din = b0; tick;
        ifc0.mem_din = b1; tick;
        ifc0.mem_rdy = 0;
    endtask

    logic [17:0] atab [4];

    initial begin
        atab[0] = 18'h00123; atab[1] = 18'h00124; atab[2] = 18'h00000; atab[3] = 18'h3FFFF;
        ifc0.cs = 0; ifc0.addr = '0; ifc0.mem_ack = 0; ifc0.mem_rdy = 0; ifc0.mem_din = '0;
        rst = 1;
        tick;
        chk_en = 1;
        tick;
        rst = 0;
        check("rst_ok",    ifc0.ok, 1'b0);
        check("rst_data",  ifc0.data, 32'h0);
        check("rst_req",   ifc0.mem_req, 1'b0);

        // Miss on 0x123: request one cycle after cs, ack three cycles later, then two beats
        ifc0.cs = 1; ifc0.addr = 18'h00123;
        tick;
        check("miss_req",  ifc0.mem_req, 1'b1);
        check("miss_addr", ifc0.mem_addr, 19'h00246);
        tick; tick;
        check("miss_hold", ifc0.mem_req, 1'b1);
        ifc0.mem_ack = 1; tick; ifc0.mem_ack = 0;
        check("ack_clr",   ifc0.mem_req, 1'b0);
        ifc0.mem_rdy = 1; ifc0.mem_din = 16'hBEEF; tick;
        ifc0.mem_din = 16'hDEAD; tick;
        ifc0.mem_rdy = 0;
        check("fill_d0",   ifc0.data, 32'hDEAD_BEEF);
        check("fill_d1",   ifc1.data, 32'hBEEF_DEAD);
        check("fill_ok",   ifc0.ok, 1'b1);

        // Hit after cs toggle
        ifc0.cs = 0; tick;
        ifc0.cs = 1; #1;
        check("hit_ok",    ifc0.ok, 1'b1);
        tick;
        check("hit_noreq", ifc0.mem_req, 1'b0);

        // Swapped beat order
        ifc0.addr = 18'h00300; tick;
        fetch_fill(16'h1234, 16'h5678);
        check("swab1",     ifc1.data, 32'h1234_5678);
        check("swab0",     ifc0.data, 32'h5678_1234);

        // Spurious traffic while idle with cs low
        ifc0.cs = 0;
        for (int i = 0; i < 4; i++) begin
            ifc0.mem_ack = 1; ifc0.mem_rdy = 1; ifc0.mem_din = 16'($urandom); tick;
        end
        ifc0.mem_ack = 0; ifc0.mem_rdy = 0;
        ifc0.cs = 1; ifc0.addr = 18'h00300; #1;
        check("spur_ok",   ifc0.ok, 1'b1);
        check("spur_data", ifc1.data, 32'h1234_5678);
        tick;
        check("spur_req",  ifc0.mem_req, 1'b0);

        // Address change during BEAT0
        ifc0.addr = 18'h00123; tick;
        ifc0.mem_ack = 1; tick; ifc0.mem_ack = 0;
        ifc0.addr = 18'h00124;
        ifc0.mem_rdy = 1; ifc0.mem_din = 16'h1111; tick;
        ifc0.mem_din = 16'h2222; tick;
        ifc0.mem_rdy = 0;
        check("chg_ok",    ifc0.ok, 1'b0);
        ifc0.addr = 18'h00123; #1;
        check("chg_tag",   ifc0.ok, 1'b1);
        check("chg_data",  ifc0.data, 32'h2222_1111);
        ifc0.addr = 18'h00124; tick;
        check("chg_req",   ifc0.mem_req, 1'b1);
        check("chg_addr",  ifc0.mem_addr, 19'h00248);
        fetch_fill(16'h3333, 16'h4444);
        check("chg_fill",  ifc0.data, 32'h4444_3333);

        // Reset in BEAT1 followed by a stray beat
        ifc0.addr = 18'h00040; tick;
        ifc0.mem_ack = 1; tick; ifc0.mem_ack = 0;
        ifc0.mem_rdy = 1; ifc0.mem_din = 16'hAAAA; tick;
        ifc0.mem_rdy = 0;
        rst = 1; ifc0.cs = 0; tick;
        rst = 0;
        ifc0.mem_rdy = 1; ifc0.mem_din = 16'h5555; tick;
        ifc0.mem_rdy = 0;
        check("mrst_req",  ifc0.mem_req, 1'b0);
        check("mrst_d0",   ifc0.data, 32'h0);
        check("mrst_d1",   ifc1.data, 32'h0);
        ifc0.cs = 1; ifc0.addr = 18'h00000; #1;
        check("mrst_ok",   ifc0.ok, 1'b0);
        ifc0.cs = 0;
        tick;

        // Random traffic, including ack/beat pulses in every state and occasional reset
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            ifc0.cs = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 4) == 0) ifc0.addr = 18'($urandom);
                else ifc0.addr = atab[$urandom_range(0, 3)];
            end
            ifc0.mem_ack = ($urandom_range(0, 2) == 0);
            ifc0.mem_rdy = ($urandom_range(0, 1) == 0);
            ifc0.mem_din = 16'($urandom);
            tick;
        end
        rst = 0; ifc0.cs = 0; ifc0.mem_ack = 0; ifc0.mem_rdy = 0;
        tick;
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
